// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester and memory-side bus bundle for the arbiter.
// Ports (slave = arbiter view):
//   fetch side  FetchReq/FetchAddr in, FetchAck/FetchErr/FetchData out
//   data side   DataReq/DataWe/DataAddr/DataWidth/DataSignExt/DataWdata in,
//               DataAck/DataErr/DataRdata out
//   memory side MemAddr/MemWdata/MemByteEn/MemRead/MemWrite out,
//               MemRdata/MemReadOK/MemWriteOK in
interface mem_bus_arbiter_if;
    logic        FetchReq;
    logic [31:0] FetchAddr;
    logic        FetchAck;
    logic        FetchErr;
    logic [31:0] FetchData;
    logic        DataReq;
    logic        DataWe;
    logic [31:0] DataAddr;
    logic [1:0]  DataWidth;
    logic        DataSignExt;
    logic [31:0] DataWdata;
    logic        DataAck;
    logic        DataErr;
    logic [31:0] DataRdata;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [3:0]  MemByteEn;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemRdata;
    logic        MemReadOK;
    logic        MemWriteOK;

    modport slave (
        input  FetchReq, FetchAddr, DataReq, DataWe, DataAddr, DataWidth, DataSignExt, DataWdata,
               MemRdata, MemReadOK, MemWriteOK,
        output FetchAck, FetchErr, FetchData, DataAck, DataErr, DataRdata,
               MemAddr, MemWdata, MemByteEn, MemRead, MemWrite
    );

    modport master (
        output FetchReq, FetchAddr, DataReq, DataWe, DataAddr, DataWidth, DataSignExt, DataWdata,
               MemRdata, MemReadOK, MemWriteOK,
        input  FetchAck, FetchErr, FetchData, DataAck, DataErr, DataRdata,
               MemAddr, MemWdata, MemByteEn, MemRead, MemWrite
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter between an instruction fetch port and a load/store port onto one memory bus.
// Ports:
//   CoreClock   in  sole clock, rising edge
//   CoreResetN  in  asynchronous active-low reset
//   bus         mem_bus_arbiter_if.slave, fetch/data requester ports and memory port
// Parameter TIMEOUT_CYCLES: strobe cycles an access may wait for OK before erroring (0 disables).
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  CoreClock,
    input  logic                  CoreResetN,
    mem_bus_arbiter_if.slave      bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, RESP} state_t;

    state_t      state, state_nx;
    logic        last_grant;
    logic        owner;
    logic        err;
    logic [1:0]  lo;
    logic [1:0]  width;
    logic        sext;
    logic [31:0] cnt;
    logic        grant_f, grant_d, f_bad, d_bad, access, ok, timeout;
    logic [31:0] lane_data, load_sh, load_val;
    logic [3:0]  lane_be;

    // last_grant = 1 means the data port won last, so fetch wins the next tie.
    assign grant_f = bus.FetchReq && (!bus.DataReq || last_grant);
    assign grant_d = bus.DataReq && !grant_f;
    assign f_bad   = |bus.FetchAddr[1:0];
    assign d_bad   = (bus.DataWidth == 2'b11) ||
                     (bus.DataWidth == 2'b01 && bus.DataAddr[0]) ||
                     (bus.DataWidth == 2'b10 && |bus.DataAddr[1:0]);
    assign access  = state == FETCH || state == LOAD || state == STORE;
    assign ok      = state == STORE ? bus.MemWriteOK : bus.MemReadOK;
    assign timeout = TIMEOUT_CYCLES != 0 && cnt == TIMEOUT_CYCLES - 1;

    assign lane_data = bus.DataWidth == 2'b00 ? {4{bus.DataWdata[7:0]}} :
                       bus.DataWidth == 2'b01 ? {2{bus.DataWdata[15:0]}} : bus.DataWdata;
    assign lane_be   = bus.DataWidth == 2'b00 ? 4'b0001 << bus.DataAddr[1:0] :
                       bus.DataWidth == 2'b01 ? (bus.DataAddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    // Loads read the full word; the addressed lane is shifted down and extended.
    assign load_sh  = bus.MemRdata >> {lo, 3'b000};
    assign load_val = width == 2'b00 ? {{24{sext & load_sh[7]}}, load_sh[7:0]} :
                      width == 2'b01 ? {{16{sext & load_sh[15]}}, load_sh[15:0]} : load_sh;

    assign bus.MemRead  = state == FETCH || state == LOAD;
    assign bus.MemWrite = state == STORE;
    assign bus.FetchAck = state == RESP && !owner && !err;
    assign bus.FetchErr = state == RESP && !owner && err;
    assign bus.DataAck  = state == RESP && owner && !err;
    assign bus.DataErr  = state == RESP && owner && err;

    always_ff @(posedge CoreClock or negedge CoreResetN) begin
        if (!CoreResetN)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        state_nx = grant_f ? (f_bad ? RESP : FETCH) :
                                    grant_d ? (d_bad ? RESP : (bus.DataWe ? STORE : LOAD)) : IDLE;
            FETCH, LOAD: state_nx = bus.MemReadOK || timeout ? RESP : state;
            STORE:       state_nx = bus.MemWriteOK || timeout ? RESP : STORE;
            default:     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CoreClock or negedge CoreResetN) begin
        if (!CoreResetN) begin
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            err           <= 1'b0;
            lo            <= '0;
            width         <= '0;
            sext          <= 1'b0;
            cnt           <= '0;
            bus.MemAddr   <= '0;
            bus.MemWdata  <= '0;
            bus.MemByteEn <= '0;
            bus.FetchData <= '0;
            bus.DataRdata <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (grant_f) begin
                last_grant    <= 1'b0;
                owner         <= 1'b0;
                err           <= f_bad;
                bus.MemAddr   <= {2'b00, bus.FetchAddr[31:2]};
                bus.MemWdata  <= '0;
                bus.MemByteEn <= 4'b1111;
            end else if (grant_d) begin
                last_grant    <= 1'b1;
                owner         <= 1'b1;
                err           <= d_bad;
                lo            <= bus.DataAddr[1:0];
                width         <= bus.DataWidth;
                sext          <= bus.DataSignExt;
                bus.MemAddr   <= {2'b00, bus.DataAddr[31:2]};
                bus.MemWdata  <= lane_data;
                bus.MemByteEn <= bus.DataWe ? lane_be : 4'b1111;
            end
        end else if (access) begin
            cnt <= cnt + 1;
            if (state == FETCH && bus.MemReadOK)
                bus.FetchData <= bus.MemRdata;
            if (state == LOAD && bus.MemReadOK)
                bus.DataRdata <= load_val;
            if (timeout && !ok)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter with directed vectors.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .CoreClock  (clk),
        .CoreResetN (rst_n),
        .bus        (bus.slave)
    );

    typedef struct {logic port; logic err; logic [31:0] data;} rsp_t;
    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic [31:0] rdata;} mem_t;

    rsp_t        sb[$];
    mem_t        mq[$];
    int          tests = 0;
    int          failed = 0;
    int          delay = 0;
    bit          resp_en = 1'b1;
    int          strobe_cycles = 0;
    int          wcnt = 0;
    logic [31:0] last_f = '0;
    logic [31:0] last_d = '0;
    mem_t        m;
    rsp_t        e;
    logic        act_port, act_err;
    logic [31:0] act_data;

    function automatic void exp_f(input logic err, input logic [31:0] d);
        sb.push_back('{1'b0, err, err ? last_f : d});
        if (!err) last_f = d;
    endfunction

    function automatic void exp_d(input logic err, input logic [31:0] d);
        sb.push_back('{1'b1, err, err ? last_d : d});
        if (!err) last_d = d;
    endfunction

    function automatic void exp_m(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] be, input logic [31:0] rdata);
        mq.push_back('{we, addr, wdata, be, rdata});
    endfunction

    task automatic check(input bit good, input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (!good) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_zero(input string name);
        logic [137:0] v;
        v = {bus.FetchAck, bus.FetchErr, bus.DataAck, bus.DataErr, bus.MemRead, bus.MemWrite,
             bus.MemAddr, bus.MemWdata, bus.MemByteEn, bus.FetchData, bus.DataRdata};
        tests++;
        if (v != '0) begin
            failed++;
            $display("FAIL %s: outputs %h expected all zero", name, v);
        end
    endtask

    task automatic fetch_req(input logic [31:0] addr);
        bus.FetchAddr = addr;
        bus.FetchReq = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.FetchAck || bus.FetchErr) begin
                bus.FetchReq = 1'b0;
                return;
            end
        end
        tests++;
        failed++;
        $display("FAIL fetch_wait: no response for addr %h within 40 cycles", addr);
        bus.FetchReq = 1'b0;
    endtask

    task automatic data_req(input logic we, input logic [31:0] addr, input logic [1:0] w,
                            input logic sx, input logic [31:0] wd);
        bus.DataWe = we;
        bus.DataAddr = addr;
        bus.DataWidth = w;
        bus.DataSignExt = sx;
        bus.DataWdata = wd;
        bus.DataReq = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.DataAck || bus.DataErr) begin
                bus.DataReq = 1'b0;
                return;
            end
        end
        tests++;
        failed++;
        $display("FAIL data_wait: no response for addr %h within 40 cycles", addr);
        bus.DataReq = 1'b0;
    endtask

    // Memory model: checks each access on its first strobe cycle, answers after 'delay' cycles.
    initial begin
        bus.MemReadOK = 1'b0;
        bus.MemWriteOK = 1'b0;
        bus.MemRdata = '0;
        m = '{1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
        forever begin
            @(negedge clk);
            bus.MemReadOK = 1'b0;
            bus.MemWriteOK = 1'b0;
            if (bus.MemRead || bus.MemWrite) begin
                strobe_cycles++;
                if (wcnt == 0) begin
                    tests++;
                    if (mq.size() == 0) begin
                        failed++;
                        $display("FAIL mem_unexpected: strobe rd=%b wr=%b addr %h with no access expected",
                                 bus.MemRead, bus.MemWrite, bus.MemAddr);
                        m = '{1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
                    end else begin
                        m = mq.pop_front();
                        if (bus.MemWrite != m.we || bus.MemRead == m.we || bus.MemAddr != m.addr ||
                            bus.MemByteEn != m.be || (m.we && bus.MemWdata != m.wdata)) begin
                            failed++;
                            $display("FAIL mem_access: got we=%b addr=%h wdata=%h be=%b expected we=%b addr=%h wdata=%h be=%b",
                                     bus.MemWrite, bus.MemAddr, bus.MemWdata, bus.MemByteEn,
                                     m.we, m.addr, m.wdata, m.be);
                        end
                    end
                end
                if (resp_en && wcnt == delay) begin
                    bus.MemRdata = m.rdata;
                    bus.MemReadOK = bus.MemRead;
                    bus.MemWriteOK = bus.MemWrite;
                end
                wcnt++;
            end else
                wcnt = 0;
        end
    end

    // Response monitor: every Ack/Err cycle pops one scoreboard entry.
    initial forever begin
        @(negedge clk);
        if (bus.FetchAck || bus.FetchErr || bus.DataAck || bus.DataErr) begin
            tests++;
            act_port = bus.DataAck || bus.DataErr;
            act_err = bus.FetchErr || bus.DataErr;
            act_data = act_port ? bus.DataRdata : bus.FetchData;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL rsp_unexpected: port=%b err=%b data=%h with nothing expected", act_port, act_err, act_data);
            end else begin
                e = sb.pop_front();
                if ($countones({bus.FetchAck, bus.FetchErr, bus.DataAck, bus.DataErr}) != 1 ||
                    e.port != act_port || e.err != act_err || e.data != act_data) begin
                    failed++;
                    $display("FAIL rsp: got fa=%b fe=%b da=%b de=%b data=%h expected port=%b err=%b data=%h",
                             bus.FetchAck, bus.FetchErr, bus.DataAck, bus.DataErr, act_data, e.port, e.err, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.FetchReq = 1'b0;
        bus.FetchAddr = '0;
        bus.DataReq = 1'b0;
        bus.DataWe = 1'b0;
        bus.DataAddr = '0;
        bus.DataWidth = '0;
        bus.DataSignExt = 1'b0;
        bus.DataWdata = '0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        exp_m(1'b0, 32'h0000_0004, 32'h0, 4'hF, 32'h0000_0013); exp_f(1'b0, 32'h0000_0013);
        fetch_req(32'h0000_0010);
        exp_m(1'b0, 32'h0, 32'h0, 4'hF, 32'h80FF_0000); exp_d(1'b0, 32'hFFFF_FF80);
        data_req(1'b0, 32'h0000_0003, 2'b00, 1'b1, 32'h0);
        exp_m(1'b0, 32'h0, 32'h0, 4'hF, 32'h80FF_0000); exp_d(1'b0, 32'h0000_80FF);
        data_req(1'b0, 32'h0000_0002, 2'b01, 1'b0, 32'h0);
        delay = 2;
        exp_m(1'b1, 32'h0, 32'hABCD_ABCD, 4'b1100, 32'h0); exp_d(1'b0, last_d);
        data_req(1'b1, 32'h0000_0002, 2'b01, 1'b0, 32'h0000_ABCD);
        delay = 1;
        exp_m(1'b1, 32'h0000_0040, 32'h5A5A_5A5A, 4'b0010, 32'h0); exp_d(1'b0, last_d);
        data_req(1'b1, 32'h0000_0101, 2'b00, 1'b0, 32'h1234_565A);
        delay = 0;
        exp_m(1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 4'b1111, 32'h0); exp_d(1'b0, last_d);
        data_req(1'b1, 32'h0000_0200, 2'b10, 1'b0, 32'hDEAD_BEEF);
        exp_m(1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'h1122_3344); exp_d(1'b0, 32'h1122_3344);
        data_req(1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0);
        exp_m(1'b0, 32'h0, 32'h0, 4'hF, 32'h1234_8001); exp_d(1'b0, 32'hFFFF_8001);
        data_req(1'b0, 32'h0000_0000, 2'b01, 1'b1, 32'h0);
        exp_m(1'b0, 32'h0, 32'h0, 4'hF, 32'h0000_F000); exp_d(1'b0, 32'h0000_00F0);
        data_req(1'b0, 32'h0000_0001, 2'b00, 1'b0, 32'h0);

        strobe_cycles = 0;
        exp_d(1'b1, 32'h0); data_req(1'b0, 32'h0000_0101, 2'b10, 1'b0, 32'h0);
        exp_f(1'b1, 32'h0); fetch_req(32'h0000_0002);
        exp_d(1'b1, 32'h0); data_req(1'b1, 32'h0000_0000, 2'b11, 1'b0, 32'h0);
        exp_d(1'b1, 32'h0); data_req(1'b0, 32'h0000_0001, 2'b01, 1'b0, 32'h0);
        check(strobe_cycles == 0, "misaligned_no_strobe", strobe_cycles, 0);

        resp_en = 1'b0;
        strobe_cycles = 0;
        exp_m(1'b0, 32'h0000_0018, 32'h0, 4'hF, 32'h0); exp_d(1'b1, 32'h0);
        data_req(1'b0, 32'h0000_0060, 2'b10, 1'b0, 32'h0);
        check(strobe_cycles == 4, "timeout_strobe_cycles", strobe_cycles, 4);

        exp_m(1'b0, 32'h0000_001C, 32'h0, 4'hF, 32'h0);
        bus.DataWe = 1'b0;
        bus.DataAddr = 32'h0000_0070;
        bus.DataWidth = 2'b10;
        bus.DataReq = 1'b1;
        for (int i = 0; i < 10 && !bus.MemRead; i++) @(negedge clk);
        check(bus.MemRead == 1'b1, "abort_strobe_up", bus.MemRead, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("abort_async");
        bus.DataReq = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_f = '0;
        last_d = '0;
        repeat (2) @(negedge clk);
        check_zero("abort_idle");
        resp_en = 1'b1;

        exp_m(1'b0, 32'h0000_0008, 32'h0, 4'hF, 32'hAAAA_0001);
        exp_m(1'b0, 32'h0000_000C, 32'h0, 4'hF, 32'hBBBB_0002);
        exp_f(1'b0, 32'hAAAA_0001); exp_d(1'b0, 32'hBBBB_0002);
        fork
            fetch_req(32'h0000_0020);
            data_req(1'b0, 32'h0000_0030, 2'b10, 1'b0, 32'h0);
        join
        exp_m(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'h0000_0077); exp_f(1'b0, 32'h0000_0077);
        fetch_req(32'h0000_0040);
        exp_m(1'b0, 32'h0000_0014, 32'h0, 4'hF, 32'h0000_00C3);
        exp_m(1'b0, 32'h0000_0011, 32'h0, 4'hF, 32'h0000_0088);
        exp_d(1'b0, 32'h0000_00C3); exp_f(1'b0, 32'h0000_0088);
        fork
            fetch_req(32'h0000_0044);
            data_req(1'b0, 32'h0000_0050, 2'b00, 1'b0, 32'h0);
        join

        repeat (3) @(negedge clk);
        check(sb.size() == 0 && mq.size() == 0, "queues_drained", sb.size() + mq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
